// File: rtl/axi4_pkg.sv
// Shared AXI4 types, constants and helpers for the burst and lite managers.
package axi4_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_e;

    // AxSIZE encoding for a full-width beat of data_w bits.
    function automatic logic [2:0] size_from_width(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    // True when a burst of len+1 beats of 'bytes' each, starting at the
    // page offset addr_lo, runs past the end of its 4KB page.
    function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                        input logic [7:0] len,
                                        input int unsigned bytes);
        int unsigned end_b;
        end_b = 32'(addr_lo) + (32'(len) + 32'd1) * bytes;
        return end_b > 32'd4096;
    endfunction

endpackage

// File: rtl/axi4_master_timeout.sv
// Response watchdog: counts enabled cycles, restarts on clr or when disabled,
// and flags expiry on the TIMEOUT-th consecutive enabled cycle.
module axi4_master_timeout #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = en && (cnt_q == CW'(TIMEOUT - 1));

    // Next count: hold at zero when idle or on progress, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || clr) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi4_burst_master.sv
// Command-driven AXI4 manager: one INCR burst outstanding at a time, with
// streamed write/read data, 4KB guard and B/R response timeout.
// Handshakes: a transfer happens on a rising ACLK edge where valid and ready
// are both high; a valid, once raised, is held with stable payload until then.
module axi4_burst_master
    import axi4_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ID_W    = 4,
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic                wdat_valid,
    output logic                wdat_ready,
    input  logic [DATA_W-1:0]   wdat_data,
    output logic                rdat_valid,
    input  logic                rdat_ready,
    output logic [DATA_W-1:0]   rdat_data,
    output logic                rdat_last,
    output logic                cmd_done,
    output logic [1:0]          cmd_resp,
    output logic                cmd_timeout,
    output logic [ID_W-1:0]     AWID,
    output logic [ADDR_W-1:0]   AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWVALID,
    input  logic                AWREADY,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    input  logic [ID_W-1:0]     BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    output logic [ID_W-1:0]     ARID,
    output logic [ADDR_W-1:0]   ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARVALID,
    input  logic                ARREADY,
    input  logic [ID_W-1:0]     RID,
    input  logic [DATA_W-1:0]   RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY,
    output state_e              dbg_state
);
    localparam int unsigned       BYTES      = DATA_W / 8;
    localparam logic [2:0]        AX_SIZE    = size_from_width(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              write_q, write_d;
    logic [8:0]        beat_q, beat_d;
    logic [1:0]        resp_q, resp_d;
    logic              timeout_q, timeout_d;
    logic              to_en, to_clr, to_expired;

    // Latched command fields drive both address channels; only one VALID rises.
    assign AWID      = id_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = AX_SIZE;
    assign AWBURST   = BURST_INCR;
    assign ARID      = id_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = AX_SIZE;
    assign ARBURST   = BURST_INCR;
    assign WDATA     = wdat_data;
    assign WSTRB     = '1;
    assign rdat_data = RDATA;
    assign cmd_resp  = resp_q;
    assign cmd_timeout = timeout_q;
    assign dbg_state = state_q;

    // Watchdog runs only while waiting on the subordinate; any beat restarts it.
    assign to_en  = (state_q == S_B) || (state_q == S_R);
    assign to_clr = (BVALID && BREADY) || (RVALID && RREADY);

    axi4_master_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (ACLK),
        .rst     (ARESET),
        .en      (to_en),
        .clr     (to_clr),
        .expired (to_expired)
    );

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        id_d       = id_q;
        write_d    = write_q;
        beat_d     = beat_q;
        resp_d     = resp_q;
        timeout_d  = timeout_q;
        cmd_ready  = 1'b0;
        cmd_done   = 1'b0;
        AWVALID    = 1'b0;
        ARVALID    = 1'b0;
        WVALID     = 1'b0;
        WLAST      = 1'b0;
        wdat_ready = 1'b0;
        BREADY     = 1'b0;
        RREADY     = 1'b0;
        rdat_valid = 1'b0;
        rdat_last  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by reset so nothing is offered while held in reset.
                cmd_ready = !ARESET;
                if (cmd_valid && cmd_ready) begin
                    addr_d    = cmd_addr & ALIGN_MASK;
                    len_d     = cmd_len;
                    id_d      = cmd_id;
                    write_d   = cmd_write;
                    resp_d    = RESP_OKAY;
                    timeout_d = 1'b0;
                    state_d   = S_CHK;
                end
            end
            S_CHK: begin
                beat_d = '0;
                if (({1'b0, len_q} >= 9'(MAX_LEN)) ||
                    crosses_4k(addr_q[11:0], len_q, BYTES)) begin
                    resp_d  = RESP_SLVERR;
                    state_d = S_DONE;
                end else begin
                    state_d = write_q ? S_AW : S_AR;
                end
            end
            S_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_d = S_W;
            end
            S_W: begin
                WVALID     = wdat_valid;
                wdat_ready = WREADY;
                WLAST      = (beat_q == {1'b0, len_q});
                if (wdat_valid && WREADY) begin
                    beat_d = beat_q + 9'd1;
                    if (WLAST) state_d = S_B;
                end
            end
            S_B: begin
                if (to_expired) begin
                    resp_d    = RESP_DECERR;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    BREADY = 1'b1;
                    if (BVALID) begin
                        resp_d  = (BID == id_q) ? BRESP : RESP_SLVERR;
                        state_d = S_DONE;
                    end
                end
            end
            S_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = S_R;
            end
            S_R: begin
                if (to_expired) begin
                    resp_d    = RESP_DECERR;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    RREADY     = rdat_ready;
                    rdat_valid = RVALID;
                    rdat_last  = RLAST;
                    if (RVALID && rdat_ready) begin
                        beat_d = beat_q + 9'd1;
                        if (RRESP > resp_q) resp_d = RRESP;
                        if (RID != id_q) resp_d = RESP_SLVERR;
                        if (RLAST) begin
                            if (beat_q != {1'b0, len_q}) resp_d = RESP_SLVERR;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                cmd_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and command registers; reset abandons any transaction silently.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            id_q      <= '0;
            write_q   <= 1'b0;
            beat_q    <= '0;
            resp_q    <= RESP_OKAY;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            id_q      <= id_d;
            write_q   <= write_d;
            beat_q    <= beat_d;
            resp_q    <= resp_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master with a behavioural AXI4 subordinate.
module tb_axi4_burst_master;
    import axi4_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 4;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 16;
    localparam int NV      = 15;

    logic              ACLK, ARESET;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;
    logic [ID_W-1:0]   cmd_id;
    logic              wdat_valid, wdat_ready;
    logic [DATA_W-1:0] wdat_data;
    logic              rdat_valid, rdat_ready, rdat_last;
    logic [DATA_W-1:0] rdat_data;
    logic              cmd_done, cmd_timeout;
    logic [1:0]        cmd_resp;
    logic [ID_W-1:0]   AWID, ARID, BID, RID;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [7:0]        AWLEN, ARLEN;
    logic [2:0]        AWSIZE, ARSIZE;
    logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic              AWVALID, AWREADY, ARVALID, ARREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [7:0]        WSTRB;
    logic              WLAST, WVALID, WREADY, BVALID, BREADY;
    logic              RLAST, RVALID, RREADY;
    state_e            dbg_state;

    axi4_burst_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
        .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data),
        .rdat_last(rdat_last), .cmd_done(cmd_done), .cmd_resp(cmd_resp),
        .cmd_timeout(cmd_timeout),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q[$];    // expected read beats, in order
    logic [DATA_W-1:0] wsrc_q[$];   // write beats waiting to be offered
    logic [DATA_W-1:0] sh_mem[int]; // bench view of memory contents
    logic [DATA_W-1:0] sub_mem[int];// subordinate storage

    // subordinate configuration and state
    logic [1:0]  slv_resp = 2'b00;
    logic        bad_id   = 1'b0;
    logic        b_never  = 1'b0;
    logic        gap      = 1'b0;
    logic        phase    = 1'b0;
    logic        b_pend   = 1'b0;
    logic [3:0]  b_id     = '0;
    logic        r_active = 1'b0;
    int          r_cnt = 0, r_len = 0, r_word = 0;
    logic [3:0]  r_id = '0;
    int          w_idx = 0, w_word = 0, cur_len = 0;
    int          ax_count = 0, ax_valid_cycles = 0;
    logic [31:0] last_ax_addr = '0;
    logic [7:0]  last_ax_len = '0;
    logic [3:0]  last_ax_id = '0;
    logic        last_ax_wr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- subordinate + data streams ----------------
    // Inputs change on the falling edge; transfers are judged 1 unit later,
    // i.e. what will be sampled on the next rising edge.
    initial begin
        AWREADY = 0; ARREADY = 0; WREADY = 0;
        BVALID = 0; BID = '0; BRESP = '0;
        RVALID = 0; RID = '0; RRESP = '0; RLAST = 0; RDATA = '0;
        wdat_valid = 0; wdat_data = '0; rdat_ready = 0;
        forever begin
            @(negedge ACLK);
            phase   = ~phase;
            AWREADY = 1'b1;
            ARREADY = 1'b1;
            WREADY  = 1'b1;
            BVALID  = b_pend && !b_never;
            BID     = b_id;
            BRESP   = slv_resp;
            RVALID  = r_active;
            RID     = r_id;
            RRESP   = slv_resp;
            RLAST   = (r_cnt == r_len);
            RDATA   = sub_mem.exists(r_word + r_cnt) ? sub_mem[r_word + r_cnt] : '0;
            wdat_valid = (wsrc_q.size() > 0) && (!gap || phase);
            wdat_data  = (wsrc_q.size() > 0) ? wsrc_q[0] : '0;
            rdat_ready = !gap || phase;
            #1;
            if (AWVALID || ARVALID) ax_valid_cycles++;
            if (AWVALID && AWREADY) begin
                ax_count++;
                last_ax_addr = AWADDR; last_ax_len = AWLEN; last_ax_id = AWID; last_ax_wr = 1'b1;
                w_word = int'(AWADDR >> 3);
                w_idx  = 0;
                check("awsize", AWSIZE, 3);
                check("awburst", AWBURST, 1);
            end
            if (ARVALID && ARREADY) begin
                ax_count++;
                last_ax_addr = ARADDR; last_ax_len = ARLEN; last_ax_id = ARID; last_ax_wr = 1'b0;
                check("arsize", ARSIZE, 3);
                check("arburst", ARBURST, 1);
                r_active = 1'b1;
                r_cnt    = 0;
                r_len    = int'(ARLEN);
                r_word   = int'(ARADDR >> 3);
                r_id     = ARID ^ {3'b000, bad_id};
            end
            if (WVALID && WREADY) begin
                check($sformatf("wlast_beat%0d", w_idx), WLAST, (w_idx == cur_len));
                check("wstrb", WSTRB, 8'hFF);
                check($sformatf("wdata_beat%0d", w_idx), WDATA, wsrc_q[0]);
                sub_mem[w_word + w_idx] = WDATA;
                w_idx++;
                void'(wsrc_q.pop_front());
                if (WLAST) begin
                    b_pend = 1'b1;
                    b_id   = last_ax_id ^ {3'b000, bad_id};
                end
            end
            if (BVALID && BREADY) b_pend = 1'b0;
            if (RVALID && RREADY) begin
                if (RLAST) r_active = 1'b0;
                r_cnt++;
            end
            if (rdat_valid && rdat_ready) begin
                if (exp_q.size() == 0) begin
                    check("rdat_unexpected_beat", 1, 0);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    check("rdat_data", rdat_data, e);
                    check("rdat_last", rdat_last, (exp_q.size() == 0));
                end
            end
        end
    end

    // ---------------- command driver ----------------
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, output int lat, output logic [1:0] resp,
                           output logic to);
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
        #1 check("cmd_ready_idle", cmd_ready, 1);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            #1;
            if (cmd_done) begin
                lat = c;
                break;
            end
            @(negedge ACLK);
        end
        resp = cmd_resp;
        to   = cmd_timeout;
        check("cmd_done_within_bound", (lat != 0), 1);
        @(negedge ACLK);
        #1;
        check("cmd_done_one_cycle", cmd_done, 0);
        check("cmd_ready_after_done", cmd_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        logic [63:0] base;     // write beat i carries base+i
        logic        gap;      // 1-in-2 wdat_valid / rdat_ready
        logic [1:0]  slv;      // subordinate BRESP/RRESP
        logic        bad;      // subordinate returns a wrong ID
        logic        rej;      // rejected locally, no bus activity
        logic [1:0]  exp_resp;
        int          exp_lat;  // 0 = not checked
    } vec_t;

    vec_t vecs[NV];

    initial begin
        vec_t        v;
        int          lat, ax0, axv0, hit, done_seen, word;
        logic [1:0]  resp;
        logic        to;

        vecs[0]  = '{1'b1, 32'h20,   8'd0,  4'd1, 64'h1111_2222_3333_4444, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 5};
        vecs[1]  = '{1'b0, 32'h20,   8'd0,  4'd2, 64'h0,  1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4};
        vecs[2]  = '{1'b1, 32'h100,  8'd3,  4'd3, 64'hA0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 0};
        vecs[3]  = '{1'b0, 32'h100,  8'd3,  4'd4, 64'h0,  1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 0};
        vecs[4]  = '{1'b1, 32'hFF0,  8'd3,  4'd5, 64'hB0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 2};
        vecs[5]  = '{1'b1, 32'h40,   8'd16, 4'd6, 64'hB8, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 2};
        vecs[6]  = '{1'b0, 32'hFF0,  8'd3,  4'd7, 64'h0,  1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 2};
        vecs[7]  = '{1'b1, 32'h2000, 8'd1,  4'd8, 64'hD0, 1'b0, 2'd3, 1'b0, 1'b0, 2'd3, 0};
        vecs[8]  = '{1'b0, 32'h2000, 8'd1,  4'd9, 64'h0,  1'b0, 2'd3, 1'b0, 1'b0, 2'd3, 0};
        vecs[9]  = '{1'b1, 32'hFE0,  8'd3,  4'd10, 64'hE0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 0};
        vecs[10] = '{1'b0, 32'hFE0,  8'd3,  4'd11, 64'h0,  1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 0};
        vecs[11] = '{1'b1, 32'h27,   8'd0,  4'd12, 64'h77, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 5};
        vecs[12] = '{1'b1, 32'h400,  8'd0,  4'd5, 64'h55, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 0};
        vecs[13] = '{1'b0, 32'h20,   8'd0,  4'd7, 64'h0,  1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 0};
        vecs[14] = '{1'b1, 32'h800,  8'd15, 4'd13, 64'h1000, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 0};

        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        ARESET = 1'b1;

        // reset values
        repeat (3) @(negedge ACLK);
        #1;
        check("rst_valids", {AWVALID, ARVALID, WVALID, BREADY, RREADY}, 0);
        check("rst_stream", {rdat_valid, wdat_ready, cmd_done, cmd_timeout}, 0);
        check("rst_cmd_resp", cmd_resp, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        #1 check("cmd_ready_after_release", cmd_ready, 1);

        // table-driven commands
        for (int i = 0; i < NV; i++) begin
            v        = vecs[i];
            slv_resp = v.slv;
            bad_id   = v.bad;
            gap      = v.gap;
            cur_len  = int'(v.len);
            word     = int'(v.addr >> 3);
            if (v.wr && !v.rej) begin
                for (int j = 0; j <= int'(v.len); j++) begin
                    wsrc_q.push_back(v.base + 64'(j));
                    sh_mem[word + j] = v.base + 64'(j);
                end
            end
            if (!v.wr && !v.rej) begin
                for (int j = 0; j <= int'(v.len); j++) exp_q.push_back(sh_mem[word + j]);
            end
            ax0  = ax_count;
            axv0 = ax_valid_cycles;
            run_cmd(v.wr, v.addr, v.len, v.id, lat, resp, to);
            check($sformatf("v%0d_resp", i), resp, v.exp_resp);
            check($sformatf("v%0d_timeout", i), to, 0);
            if (v.exp_lat != 0) check($sformatf("v%0d_latency", i), lat, v.exp_lat);
            if (v.rej) begin
                check($sformatf("v%0d_no_bus_activity", i), ax_valid_cycles, axv0);
            end else begin
                check($sformatf("v%0d_ax_count", i), ax_count, ax0 + 1);
                check($sformatf("v%0d_ax_addr", i), last_ax_addr, v.addr & ~32'h7);
                check($sformatf("v%0d_ax_len", i), last_ax_len, v.len);
                check($sformatf("v%0d_ax_id", i), last_ax_id, v.id);
                check($sformatf("v%0d_ax_dir", i), last_ax_wr, v.wr);
            end
            check($sformatf("v%0d_rbeats_left", i), exp_q.size(), 0);
            check($sformatf("v%0d_wbeats_left", i), wsrc_q.size(), 0);
        end
        slv_resp = 2'b00; bad_id = 1'b0; gap = 1'b0;

        // B never arrives: abort exactly TIMEOUT cycles after B entry
        b_never = 1'b1;
        cur_len = 0;
        wsrc_q.push_back(64'hF00D);
        run_cmd(1'b1, 32'h300, 8'd0, 4'd8, lat, resp, to);
        check("to_latency", lat, 4 + TIMEOUT);
        check("to_resp", resp, 2'b11);
        check("to_flag", to, 1);
        b_never = 1'b0;
        b_pend  = 1'b0;
        wsrc_q.push_back(64'hBEEF);
        run_cmd(1'b1, 32'h300, 8'd0, 4'd8, lat, resp, to);
        check("after_to_resp", resp, 2'b00);
        check("after_to_flag", to, 0);
        check("after_to_latency", lat, 5);

        // reset raised in the middle of a 4-beat write
        cur_len = 3;
        for (int j = 0; j < 4; j++) wsrc_q.push_back(64'hC0 + 64'(j));
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_len = 8'd3; cmd_id = 4'd9;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        hit = 0;
        for (int c = 0; c < 50; c++) begin
            #2;
            if (w_idx == 2) begin
                hit = 1;
                break;
            end
            @(negedge ACLK);
        end
        check("reset_reached_w_beat", hit, 1);
        ARESET = 1'b1;
        #1;
        check("midrst_valids", {AWVALID, ARVALID, WVALID, BREADY, RREADY}, 0);
        check("midrst_stream", {rdat_valid, wdat_ready, cmd_done, cmd_ready}, 0);
        check("midrst_resp", cmd_resp, 0);
        wsrc_q.delete();
        b_pend = 1'b0;
        w_idx  = 0;
        done_seen = 0;
        repeat (3) begin
            @(negedge ACLK);
            #1 if (cmd_done) done_seen = 1;
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        #1 check("midrst_ready_after_release", cmd_ready, 1);
        repeat (3) begin
            @(negedge ACLK);
            #1 if (cmd_done) done_seen = 1;
        end
        check("midrst_no_done", done_seen, 0);
        cur_len = 1;
        wsrc_q.push_back(64'h6000);
        wsrc_q.push_back(64'h6001);
        run_cmd(1'b1, 32'h600, 8'd1, 4'd2, lat, resp, to);
        check("fresh_write_resp", resp, 2'b00);
        check("fresh_write_timeout", to, 0);
        check("fresh_write_beats_left", wsrc_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
